// File: rtl/dwa_element_selector.sv
// dwa_element_selector
//
// Data-weighted-averaging element selector for the DEM-DAC path. The input is
// a quantized level, counted as a number of unit elements. The block turns it
// into a per-element enable vector. A rotating pointer moves the block of
// enabled elements forward on every sample. This spreads element usage evenly,
// so element mismatch is first-order noise-shaped. Static mode bypasses the
// rotation and produces a plain thermometer code.
//
// Ports
//   clk_i          clock; all state updates on the rising edge
//   rst_ni         asynchronous active-low reset
//   level_i        unsigned level; the number of elements to enable
//   level_valid_i  level_i carries a new sample this cycle
//   mode_i         0 = DWA rotation, 1 = static thermometer
//   ptr_clr_i      synchronous pointer clear; takes effect with or without a sample
//   element_sel_o  registered element enables; bit k drives unit element k
//   sel_valid_o    element_sel_o was updated from a sample on the last edge
//   pointer_o      rotation pointer; the start index of the next sample
//   overrange_o    the last accepted sample exceeded NUM_ELEMENTS and was clamped

module dwa_element_selector #(
  parameter int unsigned NUM_ELEMENTS = 16,
  parameter int unsigned LEVEL_WIDTH  = 5,
  localparam int unsigned PTR_WIDTH   = $clog2(NUM_ELEMENTS)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [LEVEL_WIDTH-1:0]  level_i,
  input  logic                    level_valid_i,
  input  logic                    mode_i,
  input  logic                    ptr_clr_i,
  output logic [NUM_ELEMENTS-1:0] element_sel_o,
  output logic                    sel_valid_o,
  output logic [PTR_WIDTH-1:0]    pointer_o,
  output logic                    overrange_o
);

  // One extra bit holds both L = NUM_ELEMENTS and s + L <= 2*NUM_ELEMENTS-1.
  localparam int unsigned IDX_WIDTH = PTR_WIDTH + 1;

  logic [PTR_WIDTH-1:0]    ptr_q;
  logic [NUM_ELEMENTS-1:0] sel_q;
  logic                    sel_valid_q;
  logic                    overrange_q;

  logic                    overrange_c;
  logic [IDX_WIDTH-1:0]    len_c;
  logic [PTR_WIDTH-1:0]    start_c;
  logic [IDX_WIDTH-1:0]    sum_c;
  logic [IDX_WIDTH-1:0]    sum_wrap_c;
  logic [PTR_WIDTH-1:0]    next_ptr_c;
  logic [NUM_ELEMENTS-1:0] dwa_mask_c;
  logic [NUM_ELEMENTS-1:0] therm_mask_c;
  logic [IDX_WIDTH-1:0]    offs_c;

  // Clamp the level to the element count and pick the start index.
  always_comb begin
    overrange_c = (level_i > LEVEL_WIDTH'(NUM_ELEMENTS));
    len_c       = overrange_c ? IDX_WIDTH'(NUM_ELEMENTS) : IDX_WIDTH'(level_i);
    start_c     = ptr_clr_i ? '0 : ptr_q;
  end

  // Compute the next pointer as (s + L) mod N, using one compare-and-subtract.
  always_comb begin
    sum_c      = {1'b0, start_c} + len_c;
    sum_wrap_c = sum_c;
    if (sum_c >= IDX_WIDTH'(NUM_ELEMENTS)) begin
      sum_wrap_c = sum_c - IDX_WIDTH'(NUM_ELEMENTS);
    end
    next_ptr_c = mode_i ? start_c : PTR_WIDTH'(sum_wrap_c);
  end

  // Build the element masks.
  // Element k is on in DWA mode when its circular distance from s is below L.
  always_comb begin
    dwa_mask_c   = '0;
    therm_mask_c = '0;
    offs_c       = '0;
    for (int unsigned k = 0; k < NUM_ELEMENTS; k++) begin
      offs_c = IDX_WIDTH'(k) + IDX_WIDTH'(NUM_ELEMENTS) - {1'b0, start_c};
      if (offs_c >= IDX_WIDTH'(NUM_ELEMENTS)) begin
        offs_c = offs_c - IDX_WIDTH'(NUM_ELEMENTS);
      end
      dwa_mask_c[k]   = (offs_c < len_c);
      therm_mask_c[k] = (IDX_WIDTH'(k) < len_c);
    end
  end

  // Output and pointer registers. When no sample arrives they hold their
  // values, except that ptr_clr_i alone still clears the pointer.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q       <= '0;
      sel_q       <= '0;
      sel_valid_q <= 1'b0;
      overrange_q <= 1'b0;
    end else begin
      sel_valid_q <= level_valid_i;
      if (level_valid_i) begin
        sel_q       <= mode_i ? therm_mask_c : dwa_mask_c;
        overrange_q <= overrange_c;
        ptr_q       <= next_ptr_c;
      end else if (ptr_clr_i) begin
        ptr_q <= '0;
      end
    end
  end

  assign element_sel_o = sel_q;
  assign sel_valid_o   = sel_valid_q;
  assign pointer_o     = ptr_q;
  assign overrange_o   = overrange_q;

endmodule
